// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with one- and two-word formats and branch redirect
// A long-format opcode (bit 15 set) pulls a second word as its immediate before the instruction is held.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir,
  output logic [15:0] imm,
  output logic [15:0] pc_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_en,
  input  logic [15:0] br_target
);

  typedef enum logic [1:0] {START, FETCH_OP, FETCH_IMM, HOLD} state_t;

  state_t      state, state_nx;
  logic [15:0] fpc, fpc_nx;
  logic [15:0] ir_nx, imm_nx, pc_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= START;
      fpc    <= RESET_PC;
      ir     <= 16'h0000;
      imm    <= 16'h0000;
      pc_out <= 16'h0000;
    end else begin
      state  <= state_nx;
      fpc    <= fpc_nx;
      ir     <= ir_nx;
      imm    <= imm_nx;
      pc_out <= pc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fpc_nx   = fpc;
    ir_nx    = ir;
    imm_nx   = imm;
    pc_nx    = pc_out;
    mem_req  = 1'b0;
    ir_valid = 1'b0;
    mem_addr = fpc;
    case (state)
      START: state_nx = FETCH_OP;
      FETCH_OP: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_nx  = mem_rdata;
          pc_nx  = fpc;
          fpc_nx = fpc + 16'h0001;
          if (mem_rdata[15]) begin
            state_nx = FETCH_IMM;
          end else begin
            imm_nx   = 16'h0000;
            state_nx = HOLD;
          end
        end
      end
      FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          imm_nx   = mem_rdata;
          fpc_nx   = fpc + 16'h0001;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        ir_valid = 1'b1;
        if (ir_ready) state_nx = FETCH_OP;
      end
      default: state_nx = START;
    endcase
    // A redirect discards whatever this cycle would have captured.
    if (br_en) begin
      state_nx = FETCH_OP;
      fpc_nx   = br_target;
      ir_nx    = ir;
      imm_nx   = imm;
      pc_nx    = pc_out;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir, imm, pc_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_en;
  logic [15:0] br_target;

  logic [15:0] mem [0:65535];
  int total = 0;
  int bad   = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir(ir), .imm(imm), .pc_out(pc_out), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .br_en(br_en), .br_target(br_target)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h0042;
    mem[16'h0002] = 16'h7777;
    mem[16'h0100] = 16'h0055;
    mem[16'hFFFF] = 16'h9000;
    rst = 1'b0; mem_ack = 1'b1; ir_ready = 1'b1; br_en = 1'b0; br_target = 16'h0000;

    #3;
    chk("rst_mem_req", {15'd0, mem_req}, 16'h0000);
    chk("rst_ir_valid", {15'd0, ir_valid}, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_imm", imm, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);

    // Short instruction from address 0
    @(negedge clk); rst = 1'b1;
    #1 chk("start_mem_req", {15'd0, mem_req}, 16'h0000);
    step();
    chk("c1_mem_req", {15'd0, mem_req}, 16'h0001);
    chk("c1_mem_addr", mem_addr, 16'h0000);
    step();
    chk("c2_ir", ir, 16'h1234);
    chk("c2_imm", imm, 16'h0000);
    chk("c2_pc_out", pc_out, 16'h0000);
    chk("c2_ir_valid", {15'd0, ir_valid}, 16'h0001);
    step();
    chk("c3_mem_addr", mem_addr, 16'h0001);

    // Wait states in FETCH_OP
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_mem_addr", mem_addr, 16'h0001);
      chk("wait_mem_req", {15'd0, mem_req}, 16'h0001);
      chk("wait_ir_valid", {15'd0, ir_valid}, 16'h0000);
    end
    mem_ack = 1'b1;
    step();
    chk("wait_ir", ir, 16'h0042);
    chk("wait_pc_out", pc_out, 16'h0001);
    chk("wait_ir_valid_hi", {15'd0, ir_valid}, 16'h0001);

    // Branch coincident with ack
    step();
    chk("br_pre_addr", mem_addr, 16'h0002);
    br_en = 1'b1; br_target = 16'h0100;
    step();
    br_en = 1'b0;
    chk("br_mem_addr", mem_addr, 16'h0100);
    chk("br_ir_valid", {15'd0, ir_valid}, 16'h0000);
    chk("br_ir_kept", ir, 16'h0042);
    chk("br_pc_kept", pc_out, 16'h0001);
    step();
    chk("br_ir", ir, 16'h0055);
    chk("br_pc_out", pc_out, 16'h0100);

    // Branch over acceptance in HOLD, then long instruction across the wrap
    br_en = 1'b1; br_target = 16'hFFFF;
    step();
    br_en = 1'b0;
    chk("wrap_addr_op", mem_addr, 16'hFFFF);
    chk("wrap_ir_valid0", {15'd0, ir_valid}, 16'h0000);
    step();
    chk("wrap_addr_imm", mem_addr, 16'h0000);
    chk("wrap_imm_valid", {15'd0, ir_valid}, 16'h0000);
    step();
    chk("wrap_ir", ir, 16'h9000);
    chk("wrap_imm", imm, 16'h1234);
    chk("wrap_pc_out", pc_out, 16'hFFFF);
    step();
    chk("wrap_next_addr", mem_addr, 16'h0001);

    // Asynchronous reset mid-fetch
    mem_ack = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_mem_req", {15'd0, mem_req}, 16'h0000);
    chk("async_ir", ir, 16'h0000);
    chk("async_pc_out", pc_out, 16'h0000);
    chk("async_imm", imm, 16'h0000);

    // Long instruction at 0, then stall in HOLD
    mem[16'h0000] = 16'h8005;
    mem[16'h0001] = 16'hABCD;
    mem_ack = 1'b1;
    @(negedge clk); rst = 1'b1;
    step();
    chk("l1_mem_addr", mem_addr, 16'h0000);
    step();
    chk("l2_mem_addr", mem_addr, 16'h0001);
    chk("l2_ir_valid", {15'd0, ir_valid}, 16'h0000);
    step();
    chk("l3_ir", ir, 16'h8005);
    chk("l3_imm", imm, 16'hABCD);
    chk("l3_pc_out", pc_out, 16'h0000);
    chk("l3_ir_valid", {15'd0, ir_valid}, 16'h0001);
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ir", ir, 16'h8005);
      chk("hold_imm", imm, 16'hABCD);
      chk("hold_pc_out", pc_out, 16'h0000);
      chk("hold_mem_req", {15'd0, mem_req}, 16'h0000);
      chk("hold_ir_valid", {15'd0, ir_valid}, 16'h0001);
    end
    ir_ready = 1'b1;
    step();
    chk("accept_mem_req", {15'd0, mem_req}, 16'h0001);
    chk("accept_mem_addr", mem_addr, 16'h0002);
    chk("accept_ir_valid", {15'd0, ir_valid}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first instruction address fetched after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port mem_req, output, 1 bit: memory read request.
REQ-005 SHALL have port mem_addr, output, 16 bits: read address, valid while mem_req=1.
REQ-006 SHALL have port mem_ack, input, 1 bit: read completes in any cycle where mem_req=1 and mem_ack=1.
REQ-007 SHALL have port mem_rdata, input, 16 bits: read data, sampled only in an ack cycle.
REQ-008 SHALL have port ir, output, 16 bits: opcode word of the held instruction.
REQ-009 SHALL have port imm, output, 16 bits: immediate word, 16'h0000 for one-word instructions.
REQ-010 SHALL have port pc_out, output, 16 bits: address of the opcode word in ir.
REQ-011 SHALL have port ir_valid, output, 1 bit: ir, imm and pc_out hold a complete instruction.
REQ-012 SHALL have port ir_ready, input, 1 bit: the decoder accepts the instruction when ir_valid=1 and ir_ready=1.
REQ-013 SHALL have port br_en, input, 1 bit: redirect fetch.
REQ-014 SHALL have port br_target, input, 16 bits: redirect address.

Function
REQ-015 SHALL implement FSM states START, FETCH_OP, FETCH_IMM and HOLD, plus a 16-bit fetch pointer fpc.
REQ-016 SHALL assert mem_req=1 only in FETCH_OP and FETCH_IMM, with mem_addr=fpc in those states.
REQ-017 SHALL move START -> FETCH_OP unconditionally on the next edge.
REQ-018 SHALL, in FETCH_OP on ack, load ir=mem_rdata and pc_out=fpc, and increment fpc by 1.
REQ-019 SHALL, on that FETCH_OP ack, go to FETCH_IMM if mem_rdata[15]=1 (long format); otherwise clear imm and go to HOLD.
REQ-020 SHALL, in FETCH_IMM on ack, load imm=mem_rdata, increment fpc by 1, and go to HOLD.
REQ-021 SHALL hold mem_addr and state unchanged while mem_req=1 and mem_ack=0 (unbounded wait).
REQ-022 SHALL drive ir_valid=1 exactly when in HOLD.
REQ-023 SHALL keep ir, imm and pc_out stable throughout HOLD.
REQ-024 SHALL move HOLD -> FETCH_OP on acceptance; HOLD persists while ir_ready=0.
REQ-025 SHALL wrap fpc arithmetic modulo 2^16 (16'hFFFF+1 = 16'h0000), including between the opcode and immediate words.
REQ-026 SHALL give latency for zero-wait memory of: opcode ack in cycle N -> ir_valid=1 in cycle N+1 (short format), or N+2 (long format).
REQ-027 SHALL, when br_en=1 in any state, set fpc=br_target, enter FETCH_OP, and drop ir_valid on the next cycle.
REQ-028 SHALL give br_en priority over a simultaneous mem_ack (data discarded, fpc not incremented) and over a simultaneous acceptance.
REQ-029 SHALL ignore mem_ack when mem_req=0.

Reset
REQ-030 SHALL, while rst=0, immediately force state=START, fpc=RESET_PC, ir=16'h0000, imm=16'h0000, pc_out=16'h0000, ir_valid=0 and mem_req=0, independent of clk.
REQ-031 SHALL abandon an in-flight fetch on reset mid-operation, and restart at RESET_PC one cycle after rst rises (START -> FETCH_OP).

Verification
REQ-032 SHALL cover: reset release, mem_ack tied 1, mem[0]=16'h1234, ir_ready=1 -> mem_addr 0000 in cycle 1; ir=1234, imm=0000, pc_out=0000, ir_valid=1 in cycle 2; next fetch at 0001.
REQ-033 SHALL cover: mem[0]=16'h8005, mem[1]=16'hABCD -> ir=8005, imm=ABCD, pc_out=0000, ir_valid=1 in cycle 3; next fetch address 0002.
REQ-034 SHALL cover: mem_ack low for 3 cycles during FETCH_OP -> mem_addr stable and ir_valid=0 throughout; ir loads on the 4th cycle.
REQ-035 SHALL cover: ir_ready=0 for 5 cycles in HOLD -> ir/imm/pc_out unchanged and mem_req=0; ir_ready=1 -> FETCH_OP next cycle.
REQ-036 SHALL cover: br_en=1, br_target=16'h0100 coincident with mem_ack -> data dropped, next mem_addr=0100, ir_valid=0.
REQ-037 SHALL cover: long instruction at 16'hFFFF -> imm fetched from 0000, pc_out=FFFF, next fetch address 0001.
